// File: rtl/bus_master_port.sv
// bus_master_port: serial bus master port.
// A local request is latched, the arbiter is asked for the bus, and then a
// frame is shifted onto the shared serial line: the address MSB first (its top
// 3 bits select the target slave), followed either by write data or by a wait
// for the slave's read response.
// Optional feature macro: MASTER_TIMEOUT_EN adds a TIMEOUT_CYCLES limit to
// the read-response wait. Without it the wait is unbounded and timeout_err is 0.
//
// Handshake: module_req is sampled only in IDLE. The edge that samples it high
// accepts the transfer, latches addr_in/data_in_parellel/rd_wrt_in and raises
// busy_out. While busy_out is high, module_req is ignored and never queued.
// Completion is signalled by a one-cycle wr_done, rd_dv or timeout_err pulse.
module bus_master_port #(
   parameter int ADDRESS_WIDTH  = 15,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     module_req,
   input  logic                     rd_wrt_in,
   input  logic [ADDRESS_WIDTH-1:0] addr_in,
   input  logic [DATA_WIDTH-1:0]    data_in_parellel,
   output logic                     arbiter_req_out,
   input  logic                     arbiter_grant_in,
   output logic                     bus_util_out,
   input  logic                     bus_util_in,
   output logic                     rd_wrt,
   inout  wire                      data_bus_serial,
   output logic [DATA_WIDTH-1:0]    data_out_parellel,
   output logic                     rd_dv,
   output logic                     wr_done,
   output logic                     timeout_err,
   output logic                     busy_out,
   output logic [2:0]               o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARB   = 3'd1,
      S_ADDR  = 3'd2,
      S_WDATA = 3'd3,
      S_RWAIT = 3'd4,
      S_RDATA = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   localparam int FRAME_W = ADDRESS_WIDTH + DATA_WIDTH;
   localparam int CNT_W   = $clog2(FRAME_W + 1);

   state_t                  r_state;
   logic [FRAME_W-1:0]      r_tx;        // {address, write data}, shifted out MSB first
   logic [DATA_WIDTH-1:0]   r_rx;        // read data being assembled
   logic                    r_dir;       // latched direction, 1 = write
   logic [CNT_W-1:0]        r_cnt;       // bit counter within the current phase
   logic                    r_oe;        // this block owns the serial line
   logic                    r_sdo;       // bit currently presented on the line
   logic                    r_arb_req;
   logic                    r_util;
   logic                    r_rd_wrt;
   logic [DATA_WIDTH-1:0]   r_rd_data;
   logic                    r_rd_dv;
   logic                    r_wr_done;
   logic                    r_busy;
   logic                    w_rx_bit;

`ifdef MASTER_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0]         r_to_cnt;
   logic                    r_timeout_err;
   assign timeout_err = r_timeout_err;
`else
   assign timeout_err = 1'b0;
`endif

   // The line is only driven while this block is sending; it is read only in
   // RWAIT/RDATA, so a floating line never reaches any state.
   assign data_bus_serial = r_oe ? r_sdo : 1'bz;
   assign w_rx_bit        = data_bus_serial;

   assign arbiter_req_out   = r_arb_req;
   assign bus_util_out      = r_util;
   assign rd_wrt            = r_rd_wrt;
   assign data_out_parellel = r_rd_data;
   assign rd_dv             = r_rd_dv;
   assign wr_done           = r_wr_done;
   assign busy_out          = r_busy;
   assign o_dbg_state       = r_state;

   // Frame sequencer: request, arbitration, address/data shift-out, read capture.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state   <= S_IDLE;
         r_tx      <= '0;
         r_rx      <= '0;
         r_dir     <= 1'b0;
         r_cnt     <= '0;
         r_oe      <= 1'b0;
         r_sdo     <= 1'b0;
         r_arb_req <= 1'b0;
         r_util    <= 1'b1;
         r_rd_wrt  <= 1'b0;
         r_rd_data <= '0;
         r_rd_dv   <= 1'b0;
         r_wr_done <= 1'b0;
         r_busy    <= 1'b0;
`ifdef MASTER_TIMEOUT_EN
         r_to_cnt      <= '0;
         r_timeout_err <= 1'b0;
`endif
      end else begin
         r_rd_dv   <= 1'b0;
         r_wr_done <= 1'b0;
`ifdef MASTER_TIMEOUT_EN
         r_timeout_err <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (module_req) begin
                  r_tx      <= {addr_in, data_in_parellel};
                  r_dir     <= rd_wrt_in;
                  r_busy    <= 1'b1;
                  r_arb_req <= 1'b1;
                  r_state   <= S_ARB;
               end
            end
            S_ARB: begin
               if (arbiter_grant_in) begin
                  r_util   <= 1'b0;
                  r_rd_wrt <= r_dir;
                  r_oe     <= 1'b1;
                  r_sdo    <= r_tx[FRAME_W-1];
                  r_tx     <= {r_tx[FRAME_W-2:0], 1'b0};
                  r_cnt    <= '0;
                  r_state  <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (r_cnt == CNT_W'(ADDRESS_WIDTH - 1)) begin
                  r_cnt <= '0;
                  if (r_dir) begin
                     r_sdo   <= r_tx[FRAME_W-1];
                     r_tx    <= {r_tx[FRAME_W-2:0], 1'b0};
                     r_state <= S_WDATA;
                  end else begin
                     r_oe    <= 1'b0;
                     r_util  <= 1'b1;
`ifdef MASTER_TIMEOUT_EN
                     r_to_cnt <= '0;
`endif
                     r_state <= S_RWAIT;
                  end
               end else begin
                  r_sdo <= r_tx[FRAME_W-1];
                  r_tx  <= {r_tx[FRAME_W-2:0], 1'b0};
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_WDATA: begin
               if (r_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                  r_oe      <= 1'b0;
                  r_util    <= 1'b1;
                  r_arb_req <= 1'b0;
                  r_rd_wrt  <= 1'b0;
                  r_wr_done <= 1'b1;
                  r_state   <= S_DONE;
               end else begin
                  r_sdo <= r_tx[FRAME_W-1];
                  r_tx  <= {r_tx[FRAME_W-2:0], 1'b0};
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_RWAIT: begin
               // Start bit: slave claims the bus and pulls the line low.
               if (!bus_util_in && (w_rx_bit == 1'b0)) begin
                  r_cnt   <= '0;
                  r_state <= S_RDATA;
               end
`ifdef MASTER_TIMEOUT_EN
               else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                  r_timeout_err <= 1'b1;
                  r_arb_req     <= 1'b0;
                  r_rd_wrt      <= 1'b0;
                  r_busy        <= 1'b0;
                  r_state       <= S_IDLE;
               end else begin
                  r_to_cnt <= r_to_cnt + TO_W'(1);
               end
`endif
            end
            S_RDATA: begin
               r_rx <= {r_rx[DATA_WIDTH-2:0], w_rx_bit};
               if (r_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                  r_rd_data <= {r_rx[DATA_WIDTH-2:0], w_rx_bit};
                  r_rd_dv   <= 1'b1;
                  r_arb_req <= 1'b0;
                  r_rd_wrt  <= 1'b0;
                  r_busy    <= 1'b0;
                  r_state   <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
